// File: rtl/modmul_core_if.sv
// Bus-side connection of the modular multiplier: operand registers and
// strobes from the local-bus interface block, result and status back to it.
interface modmul_core_if #(
  parameter int W = 12
);
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         drdy;
  logic         krdy;
  logic         en;
  logic [127:0] dout;
  logic         dvld;
  logic         kvld;
  logic         busy;
  logic         trig;

  // Bus interface block drives operands and strobes.
  modport master (
    output a, b, drdy, krdy, en,
    input  dout, dvld, kvld, busy, trig
  );

  // Multiplier core consumes operands and returns results.
  modport slave (
    input  a, b, drdy, krdy, en,
    output dout, dvld, kvld, busy, trig
  );
endinterface

// File: rtl/modmul_core.sv
// Bit-serial modular multiplier r = a*b mod Q.
// The multiplier is consumed MSB first with interleaved doubling and
// conditional addition, so each operand bit is processed in its own cycle.
// The trig output marks those cycles for capturing per-bit activity.
module modmul_core #(
  parameter int Q = 3329,
  parameter int W = 12
) (
  input  logic           clk,
  input  logic           rstn,
  modmul_core_if.slave   bus
);

  localparam int           CW = $clog2(W);
  localparam logic [W-1:0] QN = W'(Q);
  localparam logic [W:0]   QX = (W + 1)'(Q);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  ra_q, ra_d;
  logic [W-1:0]  rb_q, rb_d;
  logic [W-1:0]  r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  res_q, res_d;
  logic          dvld_q, dvld_d;
  logic          kvld_q, kvld_d;
  logic          busy_q, busy_d;
  logic          trig_q, trig_d;

  // Datapath values (one bit wider than the operands so 2r and t+ra fit).
  logic [W:0]    dbl;
  logic [W:0]    t;
  logic [W:0]    sum;
  logic [W:0]    u;

  // One iteration: t = 2r mod Q, then u = t + ra mod Q if the current
  // multiplier bit is set. Both r and ra are below Q, so a single
  // conditional subtraction keeps each step reduced.
  always_comb begin
    dbl = {r_q, 1'b0};
    t   = (dbl >= QX) ? dbl - QX : dbl;
    sum = t + {1'b0, ra_q};
    if (rb_q[cnt_q]) begin
      u = (sum >= QX) ? sum - QX : sum;
    end else begin
      u = t;
    end
  end

  // Next-state and output logic; en low freezes everything and only the
  // dvld/kvld pulses are forced low.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    busy_d  = busy_q;
    trig_d  = trig_q;
    dvld_d  = 1'b0;
    kvld_d  = 1'b0;

    if (bus.en) begin
      kvld_d = bus.krdy;
      case (state_q)
        IDLE: begin
          if (bus.drdy) begin
            ra_d    = bus.a;
            rb_d    = bus.b;
            r_d     = '0;
            busy_d  = 1'b1;
            state_d = LOAD;
          end
        end
        LOAD: begin
          // Inputs are below 2Q, so one subtraction fully reduces ra.
          ra_d    = (ra_q >= QN) ? ra_q - QN : ra_q;
          cnt_d   = CW'(W - 1);
          trig_d  = 1'b1;
          state_d = CALC;
        end
        CALC: begin
          r_d = u[W-1:0];
          if (cnt_q == '0) begin
            trig_d  = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DONE: begin
          res_d   = r_q;
          dvld_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; reset aborts any operation at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      dvld_q  <= 1'b0;
      kvld_q  <= 1'b0;
      busy_q  <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dvld_q  <= dvld_d;
      kvld_q  <= kvld_d;
      busy_q  <= busy_d;
      trig_q  <= trig_d;
    end
  end

  assign bus.dout = {{(128 - W){1'b0}}, res_q};
  assign bus.dvld = dvld_q;
  assign bus.kvld = kvld_q;
  assign bus.busy = busy_q;
  assign bus.trig = trig_q;

endmodule
